long_latency_scoreboard: RTL

// Decode-stage register scoreboard. It is the issue-side counterpart of the execute-stage

---
 rtl/long_latency_scoreboard.sv | 59 +++++
 1 files changed

// File: rtl/long_latency_scoreboard.sv
// long_latency_scoreboard: decode-stage pending-register scoreboard for variable-latency ops
module long_latency_scoreboard #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid_D,
  input  logic             RegWrite_D,
  input  logic             long_D,
  input  logic [4:0]       Rs1_D,
  input  logic [4:0]       Rs2_D,
  input  logic [4:0]       RD_D,
  input  logic             wb_valid_W,
  input  logic [4:0]       RD_LW,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushE,
  output logic [31:0]      busy_o,
  output logic [CNT_W-1:0] outstanding,
  output logic             err_o
);
  logic [31:0] pending, set_mask, clr_mask;
  logic [CNT_W-1:0] count;
  logic err, wb_valid_eff, hit1, hit2, hitd, full, stall, set;
  // a writeback landing this cycle resolves the hazard because the regfile is write-first
  function automatic logic hit(input logic [4:0] r, input logic [31:0] p, input logic wv, input logic [4:0] wr);
    return (r != 5'd0) & p[r] & ~(wv & (wr == r));
  endfunction
  always_comb begin
    wb_valid_eff = wb_valid_W & pending[RD_LW] & (RD_LW != 5'd0);
    hit1 = hit(Rs1_D, pending, wb_valid_W, RD_LW);
    hit2 = hit(Rs2_D, pending, wb_valid_W, RD_LW);
    hitd = RegWrite_D & hit(RD_D, pending, wb_valid_W, RD_LW);
    full = long_D & RegWrite_D & (count == CNT_W'(MAX_OUTSTANDING)) & ~wb_valid_eff;
    stall = ~rst & issue_valid_D & (hit1 | hit2 | hitd | full);
    set = issue_valid_D & ~stall & ~rst & RegWrite_D & long_D & (RD_D != 5'd0);
    set_mask = set ? (32'd1 << RD_D) : 32'd0;
    clr_mask = wb_valid_eff ? (32'd1 << RD_LW) : 32'd0;
  end
  // set is applied after clear so a same-register collision stays pending
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      count <= '0;
      err <= 1'b0;
    end else begin
      pending <= (pending & ~clr_mask) | set_mask;
      count <= (set & ~wb_valid_eff) ? count + 1'b1 : (~set & wb_valid_eff) ? count - 1'b1 : count;
      err <= err | (wb_valid_W & ~wb_valid_eff);
    end
  end
  assign StallD = stall;
  assign StallF = stall;
  assign FlushE = stall;
  assign busy_o = pending;
  assign outstanding = count;
  assign err_o = err;
endmodule
